// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: request/grant handshakes of the two SRAM clients plus the registered SRAM control pins
// Ports (grouped signals):
//   read client : i_rd_req, i_rd_addr -> o_rd_gnt, o_rd_valid, o_rd_data
//   write client: i_wr_req, i_wr_addr, i_wr_data -> o_wr_gnt
//   SRAM pins   : o_SRAM_ADDR, o_SRAM_WE_N, o_SRAM_OE_N (the data bus is a separate inout)
//   slave modport is the arbiter, master modport is the clients/bench side
interface sram_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic              i_rd_req;
    logic [ADDR_W-1:0] i_rd_addr;
    logic              o_rd_gnt;
    logic              o_rd_valid;
    logic [DATA_W-1:0] o_rd_data;
    logic              i_wr_req;
    logic [ADDR_W-1:0] i_wr_addr;
    logic [DATA_W-1:0] i_wr_data;
    logic              o_wr_gnt;
    logic [ADDR_W-1:0] o_SRAM_ADDR;
    logic              o_SRAM_WE_N;
    logic              o_SRAM_OE_N;
    modport slave (
        input  i_rd_req, i_rd_addr, i_wr_req, i_wr_addr, i_wr_data,
        output o_rd_gnt, o_rd_valid, o_rd_data, o_wr_gnt,
        output o_SRAM_ADDR, o_SRAM_WE_N, o_SRAM_OE_N
    );
    modport master (
        output i_rd_req, i_rd_addr, i_wr_req, i_wr_addr, i_wr_data,
        input  o_rd_gnt, o_rd_valid, o_rd_data, o_wr_gnt,
        input  o_SRAM_ADDR, o_SRAM_WE_N, o_SRAM_OE_N
    );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: arbitrates a display read path and a render write path onto one asynchronous SRAM
// Ports:
//   i_clk, i_rst  : single clock, asynchronous active-high reset
//   bus (slave)   : read/write request-grant handshakes, read data return, registered SRAM controls
//   io_SRAM_DQ    : SRAM data bus, driven only while a write is in progress
// Reads win by default; a waiting write is forced through after STARVE_LIMIT reads.
module sram_arbiter #(
    parameter int ADDR_W       = 20,
    parameter int DATA_W       = 16,
    parameter int RD_CYCLES    = 2,
    parameter int WR_CYCLES    = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    sram_arbiter_if.slave     bus,
    inout  wire  [DATA_W-1:0] io_SRAM_DQ
);
    typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD} state_t;
    state_t            state, state_n;
    logic [1:0]        cnt, cnt_n;
    logic [3:0]        starve_cnt, starve_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic [DATA_W-1:0] wdata, wdata_n;
    logic [DATA_W-1:0] rd_data, rd_data_n;
    logic              we_n, we_n_n;
    logic              oe_n, oe_n_n;
    logic              rd_valid, rd_valid_n;
    logic              idle, force_wr, rd_gnt, wr_gnt, drive;
    // Grants are combinational but suppressed while reset is held.
    assign idle     = (state == IDLE) && !i_rst;
    assign force_wr = starve_cnt == 4'(STARVE_LIMIT);
    assign rd_gnt   = idle && bus.i_rd_req && !force_wr;
    assign wr_gnt   = idle && bus.i_wr_req && (!bus.i_rd_req || force_wr);
    // Data bus is owned by the arbiter from setup through hold so it is stable around the WE_N pulse.
    assign drive    = (state == WR_SETUP) || (state == WR_PULSE) || (state == WR_HOLD);
    assign io_SRAM_DQ      = drive ? wdata : {DATA_W{1'bz}};
    assign bus.o_rd_gnt    = rd_gnt;
    assign bus.o_wr_gnt    = wr_gnt;
    assign bus.o_rd_valid  = rd_valid;
    assign bus.o_rd_data   = rd_data;
    assign bus.o_SRAM_ADDR = addr;
    assign bus.o_SRAM_WE_N = we_n;
    assign bus.o_SRAM_OE_N = oe_n;
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        starve_n   = starve_cnt;
        addr_n     = addr;
        wdata_n    = wdata;
        rd_data_n  = rd_data;
        we_n_n     = we_n;
        oe_n_n     = oe_n;
        rd_valid_n = 1'b0;
        case (state)
            IDLE: begin
                if (rd_gnt) begin
                    state_n  = RD;
                    addr_n   = bus.i_rd_addr;
                    oe_n_n   = 1'b0;
                    cnt_n    = 2'd0;
                    // Only reads that overtake a waiting write count towards starvation.
                    starve_n = (bus.i_wr_req && !force_wr) ? starve_cnt + 4'd1 : starve_cnt;
                end else if (wr_gnt) begin
                    state_n  = WR_SETUP;
                    addr_n   = bus.i_wr_addr;
                    wdata_n  = bus.i_wr_data;
                    starve_n = 4'd0;
                end
            end
            RD: begin
                if (cnt == 2'(RD_CYCLES - 1)) begin
                    state_n    = IDLE;
                    oe_n_n     = 1'b1;
                    rd_data_n  = io_SRAM_DQ;
                    rd_valid_n = 1'b1;
                end else begin
                    cnt_n = cnt + 2'd1;
                end
            end
            WR_SETUP: begin
                state_n = WR_PULSE;
                we_n_n  = 1'b0;
                cnt_n   = 2'd0;
            end
            WR_PULSE: begin
                if (cnt == 2'(WR_CYCLES - 1)) begin
                    state_n = WR_HOLD;
                    we_n_n  = 1'b1;
                end else begin
                    cnt_n = cnt + 2'd1;
                end
            end
            WR_HOLD: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            starve_cnt <= 4'd0;
            addr       <= '0;
            wdata      <= '0;
            rd_data    <= '0;
            we_n       <= 1'b1;
            oe_n       <= 1'b1;
            rd_valid   <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            starve_cnt <= starve_n;
            addr       <= addr_n;
            wdata      <= wdata_n;
            rd_data    <= rd_data_n;
            we_n       <= we_n_n;
            oe_n       <= oe_n_n;
            rd_valid   <= rd_valid_n;
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: randomized and directed stimulus against a cycle-level reference of the arbitration rules
module tb_sram_arbiter;
    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;
    localparam int RD_CYCLES = 2;
    localparam int WR_CYCLES = 1;
    localparam int STARVE_LIMIT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    wire [DATA_W-1:0] sram_dq;

    sram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    sram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_CYCLES(RD_CYCLES),
        .WR_CYCLES(WR_CYCLES), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus(bus),
        .io_SRAM_DQ(sram_dq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    function automatic logic [DATA_W-1:0] init_val(input int i);
        return 16'(i * 16'h03C1) ^ 16'h5A5A;
    endfunction

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Physical SRAM: asynchronous read while OE_N low, written while WE_N low.
    logic [DATA_W-1:0] sram [512];
    assign sram_dq = !bus.o_SRAM_OE_N ? sram[bus.o_SRAM_ADDR[8:0]] : {DATA_W{1'bz}};
    initial begin
        for (int i = 0; i < 512; i++) sram[i] = init_val(i);
        sram[9'h123] = 16'hBEEF;
        forever begin
            @(negedge clk);
            if (!rst && !bus.o_SRAM_WE_N) sram[bus.o_SRAM_ADDR[8:0]] = sram_dq;
        end
    end

    // Reference model: arbitration rules, transaction timing windows, and an expected read-data queue.
    typedef struct { logic [DATA_W-1:0] d; int c; } rd_exp_t;
    rd_exp_t rd_q[$];
    rd_exp_t e;
    logic [DATA_W-1:0] ref_mem [512];
    int free_at = 0, sc = 0, rd_t = -1000, wr_t = -1000;
    logic [ADDR_W-1:0] rd_a = '0, wr_a = '0;
    logic [DATA_W-1:0] wr_d = '0, held = '0;
    bit in_rd, in_pulse, drv, m_idle, m_force, er, ew;
    bit last_rd_g = 0, last_wr_g = 0;
    int dut_rd_cnt = 0, dut_wr_cnt = 0, dut_rd_cyc = 0, dut_wr_cyc = 0;

    initial begin
        for (int i = 0; i < 512; i++) ref_mem[i] = init_val(i);
        ref_mem[9'h123] = 16'hBEEF;
        forever begin
            @(negedge clk);
            cyc++;
            chk("we_oe_excl", 32'(!(!bus.o_SRAM_WE_N && !bus.o_SRAM_OE_N)), 1);
            chk("gnt_onehot", 32'(!(bus.o_rd_gnt && bus.o_wr_gnt)), 1);
            if (rst) begin
                chk("rst_rd_gnt", 32'(bus.o_rd_gnt), 0);
                chk("rst_wr_gnt", 32'(bus.o_wr_gnt), 0);
                chk("rst_valid", 32'(bus.o_rd_valid), 0);
                chk("rst_rd_data", 32'(bus.o_rd_data), 0);
                chk("rst_addr", 32'(bus.o_SRAM_ADDR), 0);
                chk("rst_we_n", 32'(bus.o_SRAM_WE_N), 1);
                chk("rst_oe_n", 32'(bus.o_SRAM_OE_N), 1);
                chk("rst_dq_hiz", 32'(sram_dq === {DATA_W{1'bz}}), 1);
                rd_q.delete();
                free_at = 0; sc = 0; rd_t = -1000; wr_t = -1000; held = '0;
                last_rd_g = 0; last_wr_g = 0;
            end else begin
                in_rd    = cyc >= rd_t + 1 && cyc <= rd_t + RD_CYCLES;
                in_pulse = cyc >= wr_t + 2 && cyc <= wr_t + 1 + WR_CYCLES;
                drv      = cyc >= wr_t + 1 && cyc <= wr_t + 2 + WR_CYCLES;
                chk("oe_n", 32'(bus.o_SRAM_OE_N), 32'(!in_rd));
                chk("we_n", 32'(bus.o_SRAM_WE_N), 32'(!in_pulse));
                if (in_rd) chk("rd_pin_addr", 32'(bus.o_SRAM_ADDR), 32'(rd_a));
                if (drv) begin
                    chk("wr_pin_addr", 32'(bus.o_SRAM_ADDR), 32'(wr_a));
                    chk("wr_dq", 32'(sram_dq), 32'(wr_d));
                end else if (!in_rd) begin
                    chk("dq_hiz", 32'(sram_dq === {DATA_W{1'bz}}), 1);
                end
                if (bus.o_rd_valid) begin
                    if (rd_q.size() == 0) begin
                        chk("spurious_valid", 32'(bus.o_rd_valid), 0);
                    end else begin
                        e = rd_q.pop_front();
                        chk("rd_data", 32'(bus.o_rd_data), 32'(e.d));
                        chk("rd_latency", 32'(cyc), 32'(e.c));
                        held = e.d;
                    end
                end else if (rd_q.size() > 0 && rd_q[0].c < cyc) begin
                    chk("missing_valid", 32'(bus.o_rd_valid), 1);
                    e = rd_q.pop_front();
                end
                chk("rd_data_hold", 32'(bus.o_rd_data), 32'(held));
                m_idle  = cyc >= free_at;
                m_force = sc == STARVE_LIMIT;
                er = m_idle && bus.i_rd_req && !m_force;
                ew = m_idle && bus.i_wr_req && (!bus.i_rd_req || m_force);
                chk("rd_gnt", 32'(bus.o_rd_gnt), 32'(er));
                chk("wr_gnt", 32'(bus.o_wr_gnt), 32'(ew));
                if (er) begin
                    free_at = cyc + RD_CYCLES + 1;
                    rd_t = cyc;
                    rd_a = bus.i_rd_addr;
                    e.d = ref_mem[bus.i_rd_addr[8:0]];
                    e.c = cyc + RD_CYCLES + 1;
                    rd_q.push_back(e);
                    if (bus.i_wr_req && sc < STARVE_LIMIT) sc++;
                end
                if (ew) begin
                    free_at = cyc + WR_CYCLES + 3;
                    wr_t = cyc;
                    wr_a = bus.i_wr_addr;
                    wr_d = bus.i_wr_data;
                    ref_mem[bus.i_wr_addr[8:0]] = bus.i_wr_data;
                    sc = 0;
                end
                last_rd_g = er;
                last_wr_g = ew;
                if (bus.o_rd_gnt) begin dut_rd_cnt++; dut_rd_cyc = cyc; end
                if (bus.o_wr_gnt) begin dut_wr_cnt++; dut_wr_cyc = cyc; end
            end
        end
    end

    task automatic idle_wait(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_gnt(input bit wr, input string nm);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (wr ? last_wr_g : last_rd_g) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL %s: no grant within 100 cycles", nm);
    endtask

    task automatic rd_op(input logic [ADDR_W-1:0] a);
        bus.i_rd_req = 1'b1; bus.i_rd_addr = a;
        wait_gnt(1'b0, "rd_op");
        bus.i_rd_req = 1'b0;
    endtask

    task automatic wr_op(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.i_wr_req = 1'b1; bus.i_wr_addr = a; bus.i_wr_data = d;
        wait_gnt(1'b1, "wr_op");
        bus.i_wr_req = 1'b0;
    endtask

    int s0, w0, r1;

    initial begin
        bus.i_rd_req = 1'b0; bus.i_rd_addr = '0;
        bus.i_wr_req = 1'b0; bus.i_wr_addr = '0; bus.i_wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        rd_op(20'h00123);
        idle_wait(4);
        chk("single_read", 32'(bus.o_rd_data), 32'hBEEF);
        wr_op(20'h00010, 16'h1234);
        idle_wait(4);
        rd_op(20'h00010);
        idle_wait(4);
        chk("write_readback", 32'(bus.o_rd_data), 32'h1234);
        bus.i_rd_req = 1'b1; bus.i_rd_addr = 20'h00020;
        bus.i_wr_req = 1'b1; bus.i_wr_addr = 20'h00021; bus.i_wr_data = 16'hA5A5;
        wait_gnt(1'b0, "simul_rd");
        bus.i_rd_req = 1'b0;
        wait_gnt(1'b1, "simul_wr");
        bus.i_wr_req = 1'b0;
        chk("simul_gap", 32'(dut_wr_cyc - dut_rd_cyc), 32'(RD_CYCLES + 1));
        idle_wait(6);
        s0 = dut_rd_cnt; w0 = dut_wr_cnt;
        bus.i_wr_req = 1'b1; bus.i_wr_addr = 20'h00040; bus.i_wr_data = 16'h7777;
        bus.i_rd_req = 1'b1; bus.i_rd_addr = 20'h00041;
        for (int i = 0; i < 200 && dut_wr_cnt == w0; i++) begin
            @(posedge clk); #1;
            if (last_rd_g) bus.i_rd_addr = 20'($urandom_range(0, 255));
        end
        bus.i_wr_req = 1'b0;
        chk("starve_wr_done", 32'(dut_wr_cnt - w0), 1);
        chk("starve_reads", 32'(dut_rd_cnt - s0), 32'(STARVE_LIMIT));
        r1 = dut_rd_cnt;
        for (int i = 0; i < 20 && dut_rd_cnt == r1; i++) begin @(posedge clk); #1; end
        chk("reads_resume", 32'(dut_rd_cnt != r1), 1);
        bus.i_rd_req = 1'b0;
        idle_wait(6);
        bus.i_wr_req = 1'b1; bus.i_wr_addr = 20'h001F0; bus.i_wr_data = 16'hDEAD;
        wait_gnt(1'b1, "abort_wr_gnt");
        bus.i_wr_req = 1'b0;
        @(posedge clk); #1;
        chk("abort_in_pulse", 32'(bus.o_SRAM_WE_N), 0);
        rst = 1'b1;
        bus.i_rd_req = 1'b1; bus.i_rd_addr = 20'h00030;
        #1;
        chk("abort_we_n", 32'(bus.o_SRAM_WE_N), 1);
        chk("abort_dq_hiz", 32'(sram_dq === {DATA_W{1'bz}}), 1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_gnt(1'b0, "post_rst_rd");
        bus.i_rd_req = 1'b0;
        idle_wait(4);
        chk("post_rst_read", 32'(bus.o_rd_data), 32'(init_val(32'h30)));
        for (int i = 0; i < 2500; i++) begin
            @(posedge clk); #1;
            if (!bus.i_rd_req || last_rd_g || $urandom_range(0, 19) == 0) begin
                bus.i_rd_req  = $urandom_range(0, 2) != 0;
                bus.i_rd_addr = 20'($urandom_range(0, 255));
            end
            if (!bus.i_wr_req || last_wr_g || $urandom_range(0, 19) == 0) begin
                bus.i_wr_req  = $urandom_range(0, 1) != 0;
                bus.i_wr_addr = 20'($urandom_range(0, 255));
                bus.i_wr_data = 16'($urandom);
            end
        end
        bus.i_rd_req = 1'b0;
        bus.i_wr_req = 1'b0;
        idle_wait(10);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 20, SRAM word-address width.
REQ-002 Parameter DATA_W, default 16, SRAM data width.
REQ-003 Parameter RD_CYCLES, default 2, cycles that OE_N is held low per read (1..4).
REQ-004 Parameter WR_CYCLES, default 1, cycles that WE_N is held low per write (1..4).
REQ-005 Parameter STARVE_LIMIT, default 8, number of consecutive read grants allowed while a write waits (1..15).
REQ-006 i_clk  in  1  single system clock (108 MHz pixel clock domain); one clock, all logic on the rising edge.
REQ-007 i_rst  in  1  reset; asynchronous, active-high.
REQ-008 i_rd_req  in  1  read request from the display fetch path.
REQ-009 i_rd_addr  in  ADDR_W  read word address, sampled on grant.
REQ-010 o_rd_gnt  out  1  read accepted this cycle (combinational).
REQ-011 o_rd_valid  out  1  one-cycle pulse; o_rd_data is valid.
REQ-012 o_rd_data  out  DATA_W  read data, registered, held until the next valid.
REQ-013 i_wr_req  in  1  write request from the game/render path.
REQ-014 i_wr_addr  in  ADDR_W  write word address, sampled on grant.
REQ-015 i_wr_data  in  DATA_W  write data, sampled on grant.
REQ-016 o_wr_gnt  out  1  write accepted this cycle (combinational).
REQ-017 o_SRAM_ADDR  out  ADDR_W  SRAM address, registered.
REQ-018 io_SRAM_DQ  inout  DATA_W  SRAM data bus; driven only in the write states, else high-Z.
REQ-019 o_SRAM_WE_N  out  1  SRAM write enable, active-low, registered.
REQ-020 o_SRAM_OE_N  out  1  SRAM output enable, active-low, registered.

Function
REQ-021 FSM states SHALL be IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD. Grants SHALL be issued only in IDLE.
REQ-022 In IDLE, o_rd_gnt SHALL be i_rd_req && !force_wr, and o_wr_gnt SHALL be i_wr_req && (!i_rd_req || force_wr). force_wr SHALL be (starve_cnt == STARVE_LIMIT).
REQ-023 At most one grant SHALL be high per cycle.
REQ-024 Read grant in cycle T: at edge T, latch the address onto o_SRAM_ADDR, set OE_N=0, and enter RD. OE_N SHALL stay low for cycles T+1..T+RD_CYCLES.
REQ-025 Read completion: at edge T+RD_CYCLES, capture io_SRAM_DQ into o_rd_data, pulse o_rd_valid in cycle T+RD_CYCLES+1, set OE_N=1, and return to IDLE. Request-to-valid latency SHALL be RD_CYCLES+1.
REQ-026 Write grant in cycle T: latch the address and data at edge T.
  - WR_SETUP (cycle T+1): DQ driven, WE_N=1.
  - WR_PULSE (cycles T+2..T+1+WR_CYCLES): WE_N=0.
  - WR_HOLD (cycle T+2+WR_CYCLES): WE_N=1, DQ and address still held.
  - IDLE from cycle T+3+WR_CYCLES.
REQ-027 OE_N SHALL be 1 during all write states. WE_N and OE_N SHALL never be low together.
REQ-028 Address and DQ SHALL not change while WE_N=0 or OE_N=0.
REQ-029 starve_cnt (4 bits) SHALL increment on each read grant issued while i_wr_req=1, SHALL saturate at STARVE_LIMIT, and SHALL clear on any write grant.
REQ-030 A requester SHALL hold req and address/data stable until its grant. A req dropped before grant is not serviced.
REQ-031 Back-to-back behaviour:
  - Continuous reads yield one read per RD_CYCLES+1 cycles.
  - Continuous writes yield one write per WR_CYCLES+3 cycles.
REQ-032 o_rd_valid SHALL not assert for writes or after reset aborts a read.

Reset
REQ-033 When i_rst=1, asynchronously and regardless of state:
  - state=IDLE.
  - o_SRAM_WE_N=1, o_SRAM_OE_N=1, o_SRAM_ADDR=0, DQ high-Z.
  - o_rd_valid=0, o_rd_data=0, starve_cnt=0.
  - Grants low.
REQ-034 Reset during WR_PULSE SHALL force WE_N high immediately, with no completion or valid afterward. Operation SHALL resume with the first edge after i_rst falls.

Verification
REQ-035 Single read: RD_CYCLES=2, SRAM model holds 0xBEEF at 0x00123; i_rd_req with addr 0x00123 in cycle 0 -> o_rd_gnt in cycle 0, OE_N low in cycles 1-2, o_rd_valid=1 with o_rd_data=0xBEEF in cycle 3.
REQ-036 Single write: write 0x1234 to 0x00010 granted in cycle 0 -> WE_N=0 only in cycle 2, DQ=0x1234 in cycles 1-3, IDLE in cycle 4; a subsequent read of 0x00010 returns 0x1234.
REQ-037 Simultaneous requests: rd and wr both asserted with starve_cnt=0 -> read granted, then write granted in the first IDLE cycle after the read if rd is dropped.
REQ-038 Starvation: rd held high continuously with wr pending, STARVE_LIMIT=8 -> exactly 8 read grants, then the write is granted, then starve_cnt=0 and reads resume.
REQ-039 Reset mid-write: assert i_rst during WR_PULSE -> WE_N=1 and DQ high-Z within the same cycle, no grant or valid while reset is high, normal read after release.
REQ-040 Bus checks (assertions, all tests): never WE_N=0 && OE_N=0; one-hot grants; DQ driven only in the write states.
